seq_rec_readout: RTL
====================

# seq_rec_readout

Bus-master readout stage directly downstream of the sequence recorder. On a start pulse it arms the recorder and polls the recorder's done flag over the 8-bit basil bus. It then reads back the recorded bytes and packs them into 32-bit words for the standard basil FIFO readout path (FIFO_READ / FIFO_EMPTY / FIFO_DATA). All logic runs in BUS_CLK; the recorder's own clock-domain crossing is not repeated here.

## Interface
Parameters:
- ABUSWIDTH, 16, bus address width
- BASE_ADDR, 0, recorder base address on the bus
- MEM_BYTES, 8*1024, recorder memory size; readout length clamp
- POLL_TIMEOUT, 65535, max polling cycles before abort
- FIFO_DEPTH, 8, output word FIFO depth, power of 2

Ports:
- BUS_CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high; clock BUS_CLK
- START  in  1  single-cycle pulse, begins arm/poll/read sequence
- ABORT  in  1  single-cycle pulse, returns engine to IDLE
- BYTES  in  16  bytes to read; sampled on accepted START
- M_ADD  out  ABUSWIDTH  master bus address
- M_DATA_OUT  out  8  master write data
- M_RD  out  1  master read strobe
- M_WR  out  1  master write strobe
- M_DATA_IN  in  8  slave read data, valid one cycle after M_RD
- FIFO_READ  in  1  pop output word
- FIFO_EMPTY  out  1  no word available
- FIFO_DATA  out  32  head word, valid while !FIFO_EMPTY
- BUSY  out  1  engine not in IDLE
- TIMEOUT  out  1  sticky: last run aborted by poll timeout

## Operation
- States: IDLE, ARM, POLL_RD, POLL_CAP, READ_RD, READ_CAP, FLUSH.
- IDLE: on START, latch len = min(BYTES, MEM_BYTES), clear TIMEOUT, clear byte index, go to ARM. START outside IDLE is ignored.
- ARM: one cycle, M_WR=1, M_ADD=BASE_ADDR+1, M_DATA_OUT=0. This starts the recorder. Go to POLL_RD.
- POLL_RD: M_RD=1, M_ADD=BASE_ADDR+1. Go to POLL_CAP.
- POLL_CAP: sample M_DATA_IN[0].
  - If 1: go to READ_RD, or to IDLE if len==0.
  - If 0 and the poll counter has reached POLL_TIMEOUT: set TIMEOUT and go to IDLE.
  - Otherwise go to POLL_RD.
- READ_RD: only when the FIFO is not full (stall otherwise). M_RD=1, M_ADD=BASE_ADDR+16+idx. Go to READ_CAP.
- READ_CAP: place M_DATA_IN into byte lane idx[1:0] of the pack register (lane k = bits 8k+7:8k) and increment idx.
  - If the lane was 3: push the word.
  - If idx+1==len with lane<3: go to FLUSH.
  - Else if idx+1==len: go to IDLE.
  - Else go to READ_RD.
- FLUSH: push the pack register with unused upper lanes zero, then go to IDLE.
- Words produced per run: ceil(len/4).
- ABORT in any state: go to IDLE, drop the partial pack word, keep FIFO contents, do not set TIMEOUT.
- M_RD and M_WR are never asserted together, and are 0 in IDLE and during a stall.

## Timing
- Reset values: M_ADD=0, M_DATA_OUT=0, M_RD=0, M_WR=0, FIFO_EMPTY=1, FIFO_DATA=0, BUSY=0, TIMEOUT=0. RST clears the FIFO.
- START at cycle t puts M_WR high at t+1.
- Bus reads use 2 cycles per byte with no pipelining. Read data is sampled exactly one cycle after M_RD.
- Poll period is 2 cycles. The first poll cannot see the stale done flag, because the recorder clears it on the ARM write.
- FIFO is first-word fall-through. FIFO_DATA is valid in the same cycle FIFO_EMPTY falls.
- Push and pop may happen in the same cycle, including when the FIFO is full; occupancy is then unchanged.
- FIFO_READ while empty is ignored.
- BUSY falls in the cycle after the final push or the abort.

## Structure
- Shared package: state encoding; recorder register offsets (DONE/START reg = 1, memory offset = 16).
- One sub-module: seq_rec_readout_fifo, a synchronous FWFT FIFO, 32 bits wide × FIFO_DEPTH, with full/empty flags.

## Test plan
- BYTES=8, recorder model asserts done after 3 polls → exactly one write to addr 1, then reads of addr 16–23, then words 0x03020100 and 0x07060504 for memory content byte[i]=i.
- BYTES=5 → two words, second word 0x00000004, FIFO_EMPTY=1 afterwards.
- BYTES=0 → ARM and poll happen, no reads, FIFO stays empty, BUSY drops.
- Done flag never set with POLL_TIMEOUT=10 → TIMEOUT=1, no reads, BUSY=0, and the next START clears TIMEOUT.
- FIFO_DEPTH=2, BYTES=16, FIFO_READ held low → reads stall after 8 bytes with M_RD low. Releasing FIFO_READ completes the run with all 4 words in order.
- ABORT during READ_RD with 2 bytes of a partial word held → FIFO keeps earlier words, no partial push, BUSY=0 next cycle. RST mid-read → all outputs return to reset values.

Source files
------------

// File: rtl/seq_rec_readout_pkg.sv
// seq_rec_readout_pkg: engine state encoding and sequence recorder register map
package seq_rec_readout_pkg;
  typedef enum logic [2:0] {IDLE, ARM, POLL_RD, POLL_CAP, READ_RD, READ_CAP, FLUSH} state_t;
  localparam int REG_DONE = 1;
  localparam int MEM_OFF = 16;
endpackage

// File: rtl/seq_rec_readout_if.sv
// seq_rec_readout_if: 8-bit basil bus between the readout master and the recorder
interface seq_rec_readout_if #(parameter int ABUSWIDTH = 16) ();
  logic [ABUSWIDTH-1:0] M_ADD;
  logic [7:0] M_DATA_OUT;
  logic M_RD;
  logic M_WR;
  logic [7:0] M_DATA_IN;
  modport master (output M_ADD, M_DATA_OUT, M_RD, M_WR, input M_DATA_IN);
  modport slave (input M_ADD, M_DATA_OUT, M_RD, M_WR, output M_DATA_IN);
endinterface

// File: rtl/seq_rec_readout_fifo.sv
// seq_rec_readout_fifo: first-word fall-through FIFO, DEPTH must be a power of 2
module seq_rec_readout_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic BUS_CLK,
  input  logic RST,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop frees the head slot in the same cycle, so a full FIFO still accepts a push
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge BUS_CLK) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/seq_rec_readout.sv
// seq_rec_readout: arms the recorder, polls done, reads bytes back and packs them into 32-bit FIFO words
module seq_rec_readout import seq_rec_readout_pkg::*; #(
  parameter int ABUSWIDTH = 16,
  parameter int BASE_ADDR = 0,
  parameter int MEM_BYTES = 8*1024,
  parameter int POLL_TIMEOUT = 65535,
  parameter int FIFO_DEPTH = 8
) (
  input  logic BUS_CLK,
  input  logic RST,
  input  logic START,
  input  logic ABORT,
  input  logic [15:0] BYTES,
  seq_rec_readout_if.master bus,
  input  logic FIFO_READ,
  output logic FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic BUSY,
  output logic TIMEOUT
);
  state_t st;
  logic [15:0] len, idx;
  logic [31:0] poll_cnt, pack, push_data;
  logic [1:0] lane;
  logic push, full, last;
  assign lane = idx[1:0];
  assign last = idx + 16'd1 == len;
  assign BUSY = st != IDLE;
  assign bus.M_WR = st == ARM;
  assign bus.M_RD = st == POLL_RD || (st == READ_RD && !full);
  assign bus.M_DATA_OUT = '0;
  assign bus.M_ADD = st == READ_RD ? ABUSWIDTH'(BASE_ADDR + MEM_OFF + 32'(idx)) :
                     (st == ARM || st == POLL_RD) ? ABUSWIDTH'(BASE_ADDR + REG_DONE) : '0;
  // lane 3 is pushed straight from the bus so the pack register never holds a full word
  assign push = !ABORT && (st == FLUSH || (st == READ_CAP && lane == 2'd3));
  assign push_data = st == FLUSH ? pack : {bus.M_DATA_IN, pack[23:0]};
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      st <= IDLE;
      len <= '0;
      idx <= '0;
      poll_cnt <= '0;
      pack <= '0;
      TIMEOUT <= 1'b0;
    end else if (ABORT) begin
      st <= IDLE;
      pack <= '0;
    end else begin
      case (st)
        IDLE: if (START) begin
          st <= ARM;
          len <= 32'(BYTES) > 32'(MEM_BYTES) ? 16'(MEM_BYTES) : BYTES;
          idx <= '0;
          poll_cnt <= '0;
          pack <= '0;
          TIMEOUT <= 1'b0;
        end
        ARM: st <= POLL_RD;
        POLL_RD: st <= POLL_CAP;
        POLL_CAP: if (bus.M_DATA_IN[0]) st <= len == '0 ? IDLE : READ_RD;
          else if (poll_cnt >= 32'(POLL_TIMEOUT)) begin
            TIMEOUT <= 1'b1;
            st <= IDLE;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
            st <= POLL_RD;
          end
        READ_RD: if (!full) st <= READ_CAP;
        READ_CAP: begin
          pack <= lane == 2'd3 ? '0 : pack | (32'(bus.M_DATA_IN) << {lane, 3'b000});
          idx <= idx + 16'd1;
          st <= !last ? READ_RD : lane == 2'd3 ? IDLE : FLUSH;
        end
        FLUSH: begin
          pack <= '0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
  seq_rec_readout_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .BUS_CLK(BUS_CLK),
    .RST(RST),
    .push(push),
    .din(push_data),
    .pop(FIFO_READ),
    .dout(FIFO_DATA),
    .empty(FIFO_EMPTY),
    .full(full)
  );
endmodule
